// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: synchronizes the asynchronous PLL LOCK signal, requires
// STABLE_CYCLES consecutive locked cycles before releasing the downstream
// reset, and drops the reset with a one-cycle lock_lost pulse when lock is lost.
// Optional feature: define LOCK_LOSS_CNT_EN to add loss_clr / loss_count, a
// saturating 8-bit count of lock_lost pulses.
module pll_lock_monitor #(
   parameter int unsigned STABLE_CYCLES = 1024
) (
   input  logic       clkin,
   input  logic       rstn,
   input  logic       pll_locked,
`ifdef LOCK_LOSS_CNT_EN
   input  logic       loss_clr,
   output logic [7:0] loss_count,
`endif
   output logic       sys_rstn,
   output logic       lock_ok,
   output logic       lock_lost,
   output logic [1:0] state
);

   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      StWaitLock = 2'b00,
      StStable   = 2'b01,
      StRun      = 2'b10,
      StUnused   = 2'b11
   } state_e;

   logic            sync1_q, sync2_q;
   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sys_rstn_q, lock_ok_q, lock_lost_q;
   logic            run_d, lost_d;

   // Two-flop synchronizer; the only place pll_locked is sampled.
   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pll_locked;
         sync2_q <= sync1_q;
      end
   end

   // Next-state logic: qualify lock for STABLE_CYCLES cycles, drop out on any loss.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lost_d  = 1'b0;
      case (state_q)
         StWaitLock: begin
            cnt_d = '0;
            if (sync2_q) state_d = StStable;
         end
         StStable: begin
            if (!sync2_q) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRun: begin
            if (!sync2_q) begin
               state_d = StWaitLock;
               lost_d  = 1'b1;
            end
         end
         default: begin
            state_d = StWaitLock;
            cnt_d   = '0;
         end
      endcase
      // Outputs are registered from the next state so they change with the FSM.
      run_d = (state_d == StRun);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StWaitLock;
         cnt_q       <= '0;
         sys_rstn_q  <= 1'b0;
         lock_ok_q   <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sys_rstn_q  <= run_d;
         lock_ok_q   <= run_d;
         lock_lost_q <= lost_d;
      end
   end

   assign sys_rstn  = sys_rstn_q;
   assign lock_ok   = lock_ok_q;
   assign lock_lost = lock_lost_q;
   assign state     = state_q;

`ifdef LOCK_LOSS_CNT_EN
   logic [7:0] loss_count_q;

   // Saturating loss counter; a clear coinciding with a pulse keeps that pulse.
   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         loss_count_q <= 8'd0;
      end else if (loss_clr) begin
         loss_count_q <= lock_lost_q ? 8'd1 : 8'd0;
      end else if (lock_lost_q && (loss_count_q != 8'hff)) begin
         loss_count_q <= loss_count_q + 8'd1;
      end
   end

   assign loss_count = loss_count_q;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: two instances (STABLE_CYCLES=4 and =1) share the
// stimulus; a behavioural model pushes expected outputs to a queue on every
// edge and they are popped and compared just after the edge.
// Define LOCK_LOSS_CNT_EN to also exercise the loss counter.
module tb_pll_lock_monitor;

   typedef struct {
      int         idx;
      logic [1:0] st;
      logic       srst;
      logic       ok;
      logic       lost;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       pll_locked;
   logic       loss_clr;
   logic [1:0] st   [2];
   logic       srst [2];
   logic       ok   [2];
   logic       lost [2];
   logic [7:0] lcnt [2];

   int n_checks = 0;
   int n_errors = 0;

   exp_t sb[$];

   // Behavioural model state per instance.
   int   m_sc     [2];
   logic m_h1     [2];
   logic m_h2     [2];
   int   m_streak [2];
   logic m_run    [2];
   logic m_lost   [2];
   int   m_cnt    [2];

   logic clr_req;
   logic clr_force;

   always #5 clk = ~clk;

   pll_lock_monitor #(.STABLE_CYCLES(4)) dut0 (
      .clkin      (clk),
      .rstn       (rstn),
      .pll_locked (pll_locked),
`ifdef LOCK_LOSS_CNT_EN
      .loss_clr   (loss_clr),
      .loss_count (lcnt[0]),
`endif
      .sys_rstn   (srst[0]),
      .lock_ok    (ok[0]),
      .lock_lost  (lost[0]),
      .state      (st[0])
   );

   pll_lock_monitor #(.STABLE_CYCLES(1)) dut1 (
      .clkin      (clk),
      .rstn       (rstn),
      .pll_locked (pll_locked),
`ifdef LOCK_LOSS_CNT_EN
      .loss_clr   (loss_clr),
      .loss_count (lcnt[1]),
`endif
      .sys_rstn   (srst[1]),
      .lock_ok    (ok[1]),
      .lock_lost  (lost[1]),
      .state      (st[1])
   );

`ifndef LOCK_LOSS_CNT_EN
   assign lcnt[0] = 8'd0;
   assign lcnt[1] = 8'd0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_h1[i] = 1'b0;
         m_h2[i] = 1'b0;
         m_streak[i] = 0;
         m_run[i] = 1'b0;
         m_lost[i] = 1'b0;
         m_cnt[i] = 0;
      end
   endtask

   // One clock edge of the model: lock seen two edges late, RUN after SC+1 locked edges.
   task automatic model_edge(input int i, input logic pll, input logic clr);
      logic d;
      exp_t e;
      d = m_h2[i];
      m_h2[i] = m_h1[i];
      m_h1[i] = pll;
      if (clr) m_cnt[i] = m_lost[i] ? 1 : 0;
      else if (m_lost[i] && m_cnt[i] < 255) m_cnt[i]++;
      m_lost[i] = 1'b0;
      if (m_run[i]) begin
         if (!d) begin
            m_run[i] = 1'b0;
            m_lost[i] = 1'b1;
            m_streak[i] = 0;
         end
      end else if (!d) begin
         m_streak[i] = 0;
      end else begin
         m_streak[i]++;
         if (m_streak[i] >= m_sc[i] + 1) begin
            m_run[i] = 1'b1;
            m_streak[i] = 0;
         end
      end
      e.idx  = i;
      e.st   = m_run[i] ? 2'b10 : (m_streak[i] > 0 ? 2'b01 : 2'b00);
      e.srst = m_run[i];
      e.ok   = m_run[i];
      e.lost = m_lost[i];
      e.cnt  = 8'(m_cnt[i]);
      sb.push_back(e);
   endtask

   // Active edge, model update, then compare 1 time unit later.
   task automatic edge_tail();
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_edge(i, pll_locked, loss_clr);
      #1;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check($sformatf("state%0d", e.idx), 32'(st[e.idx]), 32'(e.st));
         check($sformatf("sys_rstn%0d", e.idx), 32'(srst[e.idx]), 32'(e.srst));
         check($sformatf("lock_ok%0d", e.idx), 32'(ok[e.idx]), 32'(e.ok));
         check($sformatf("lock_lost%0d", e.idx), 32'(lost[e.idx]), 32'(e.lost));
`ifdef LOCK_LOSS_CNT_EN
         check($sformatf("loss_count%0d", e.idx), 32'(lcnt[e.idx]), 32'(e.cnt));
`endif
      end
   endtask

   task automatic step(input logic pll);
      @(negedge clk);
      pll_locked = pll;
      loss_clr = clr_force | (clr_req & m_lost[0]);
      edge_tail();
   endtask

   // Pulse pll_locked low between edges so no flop samples it.
   task automatic step_glitch();
      @(negedge clk);
      pll_locked = 1'b1;
      loss_clr = 1'b0;
      #2 pll_locked = 1'b0;
      #1 pll_locked = 1'b1;
      edge_tail();
   endtask

   task automatic async_reset_check();
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("async_state%0d", i), 32'(st[i]), 32'd0);
         check($sformatf("async_sys_rstn%0d", i), 32'(srst[i]), 32'd0);
         check($sformatf("async_lock_ok%0d", i), 32'(ok[i]), 32'd0);
      end
      model_reset();
   endtask

   initial begin
      m_sc[0] = 4;
      m_sc[1] = 1;
      rstn = 1'b0;
      pll_locked = 1'b0;
      loss_clr = 1'b0;
      clr_req = 1'b0;
      clr_force = 1'b0;
      model_reset();
      #3;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_state%0d", i), 32'(st[i]), 32'd0);
         check($sformatf("rst_sys_rstn%0d", i), 32'(srst[i]), 32'd0);
         check($sformatf("rst_lock_lost%0d", i), 32'(lost[i]), 32'd0);
      end

      // Release with lock high from edge 1.
      @(negedge clk);
      rstn = 1'b1;
      pll_locked = 1'b1;
      edge_tail();
      for (int n = 2; n <= 10; n++) begin
         step(1'b1);
         if (n == 3) check("e3_state0", 32'(st[0]), 32'd1);
         if (n == 4) check("e4_sys_rstn1", 32'(srst[1]), 32'd1);
         if (n == 6) check("e6_state0", 32'(st[0]), 32'd1);
         if (n == 7) begin
            check("e7_state0", 32'(st[0]), 32'd2);
            check("e7_sys_rstn0", 32'(srst[0]), 32'd1);
         end
      end

      // Loss from RUN: low before edge k, pulse at k+2.
      step(1'b0);
      check("k_lost", 32'(lost[0]), 32'd0);
      step(1'b1);
      check("k1_lost", 32'(lost[0]), 32'd0);
      step(1'b1);
      check("k2_lost", 32'(lost[0]), 32'd1);
      check("k2_state", 32'(st[0]), 32'd0);
      step(1'b1);
      check("k3_lost", 32'(lost[0]), 32'd0);

      // Uncaptured glitch while in RUN.
      for (int n = 0; n < 8; n++) step(1'b1);
      step_glitch();
      for (int n = 0; n < 4; n++) step(1'b1);
      check("glitch_state", 32'(st[0]), 32'd2);

      // Short lock pulse, then re-rise.
      for (int n = 0; n < 3; n++) step(1'b0);
      for (int n = 0; n < 3; n++) step(1'b1);
      for (int n = 0; n < 2; n++) step(1'b0);
      for (int n = 1; n <= 8; n++) begin
         step(1'b1);
         if (n == 6) check("rerise6_state0", 32'(st[0]), 32'd1);
         if (n == 7) check("rerise7_state0", 32'(st[0]), 32'd2);
      end

      // Asynchronous reset in RUN, then full requalification.
      async_reset_check();
      @(negedge clk);
      rstn = 1'b1;
      pll_locked = 1'b1;
      edge_tail();
      for (int n = 2; n <= 7; n++) begin
         step(1'b1);
         if (n == 6) check("rq6_state0", 32'(st[0]), 32'd1);
      end
      check("rq7_state0", 32'(st[0]), 32'd2);
      check("rq7_sys_rstn0", 32'(srst[0]), 32'd1);

`ifdef LOCK_LOSS_CNT_EN
      // 260 losses saturate, a clear with loss 261 leaves 1, clear alone gives 0.
      for (int p = 1; p <= 261; p++) begin
         if (p == 261) begin
            step(1'b1);
            check("sat_count", 32'(lcnt[0]), 32'd255);
            clr_req = 1'b1;
            for (int n = 0; n < 7; n++) step(1'b1);
         end else begin
            for (int n = 0; n < 8; n++) step(1'b1);
         end
         for (int n = 0; n < 3; n++) step(1'b0);
      end
      step(1'b1);
      clr_req = 1'b0;
      check("clr_coincident", 32'(lcnt[0]), 32'd1);
      clr_force = 1'b1;
      step(1'b1);
      clr_force = 1'b0;
      check("clr_alone", 32'(lcnt[0]), 32'd0);
      step(1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
